// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_ctrl
// Summary  : Turns start/stop and lap/reset button levels into stopwatch
//            tick-enable and clear pulses, with a lap (split-time) freeze.
// Revision : 1.0
// ============================================================================
module stopwatch_ctrl #(
  parameter int TICK_DIV = 4,
  parameter int WIDTH    = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_stop_i,
  input  logic             lap_reset_i,
  input  logic [WIDTH-1:0] time_i,
  output logic             count_o,
  output logic             clear_o,
  output logic [WIDTH-1:0] display_o,
  output logic             lap_o,
  output logic [1:0]       state_o
);

  localparam int                 PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    LAP  = 2'b10,
    STOP = 2'b11
  } state_t;

  state_t             state;
  logic [PRESC_W-1:0] presc;
  logic [WIDTH-1:0]   lap_q;
  logic               ss_q;
  logic               lr_q;
  logic               ss_ev;
  logic               lr_ev;
  logic               counting;

  // Start/stop wins a same-cycle collision, so lap/reset is masked here.
  assign ss_ev    = start_stop_i & ~ss_q;
  assign lr_ev    = lap_reset_i & ~lr_q & ~ss_ev;
  assign counting = (state == RUN) || (state == LAP);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state   <= IDLE;
      presc   <= '0;
      lap_q   <= '0;
      ss_q    <= 1'b1;
      lr_q    <= 1'b1;
      clear_o <= 1'b0;
    end else begin
      ss_q    <= start_stop_i;
      lr_q    <= lap_reset_i;
      clear_o <= 1'b0;
      case (state)
        IDLE: begin
          presc <= '0;
          if (ss_ev) begin
            state <= RUN;
          end else if (lr_ev) begin
            clear_o <= 1'b1;
          end
        end
        RUN: begin
          presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
          if (ss_ev) begin
            state <= STOP;
          end else if (lr_ev) begin
            lap_q <= time_i;
            state <= LAP;
          end
        end
        LAP: begin
          presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
          if (ss_ev) begin
            state <= STOP;
          end else if (lr_ev) begin
            state <= RUN;
          end
        end
        STOP: begin
          // presc holds so a resumed run keeps the partial-tick phase.
          if (ss_ev) begin
            state <= RUN;
          end else if (lr_ev) begin
            clear_o <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign count_o   = counting && (presc == PRESC_LAST);
  assign display_o = (state == LAP) ? lap_q : time_i;
  assign lap_o     = (state == LAP);
  assign state_o   = state;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_ctrl
// Summary  : Self-checking bench for stopwatch_ctrl driving a behavioural
//            stopwatch counter; tick/clear pulses checked via a scoreboard.
// Revision : 1.0
// ============================================================================
module tb_stopwatch_ctrl;

  localparam int TICK_DIV = 4;
  localparam int WIDTH    = 8;

  logic             clk          = 1'b0;
  logic             reset_i      = 1'b1;
  logic             start_stop_i = 1'b0;
  logic             lap_reset_i  = 1'b0;
  logic [WIDTH-1:0] sw_time;
  logic             count_o;
  logic             clear_o;
  logic [WIDTH-1:0] display_o;
  logic             lap_o;
  logic [1:0]       state_o;

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string name;
    int    val;
  } exp_t;

  exp_t exp_q[$];
  int   tick_q[$];
  int   clr_q[$];

  stopwatch_ctrl #(
    .TICK_DIV(TICK_DIV),
    .WIDTH   (WIDTH)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .start_stop_i(start_stop_i),
    .lap_reset_i (lap_reset_i),
    .time_i      (sw_time),
    .count_o     (count_o),
    .clear_o     (clear_o),
    .display_o   (display_o),
    .lap_o       (lap_o),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural stopwatch fed by the controller.
  always @(posedge clk or posedge reset_i) begin
    if (reset_i)      sw_time <= '0;
    else if (clear_o) sw_time <= '0;
    else if (count_o) sw_time <= sw_time + 1'b1;
  end

  // Record which edge each output pulse followed.
  always @(negedge clk) begin
    if (!reset_i) begin
      if (count_o) tick_q.push_back(cyc);
      if (clear_o) clr_q.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    start_stop_i = 1'b0;
    lap_reset_i  = 1'b0;
    reset_i      = 1'b1;
    step(2);
    n_tests++; if (state_o !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %b expected 00", state_o); end
    n_tests++; if (count_o !== 1'b0 || clear_o !== 1'b0 || lap_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_outs: count=%b clear=%b lap=%b expected 0 0 0", count_o, clear_o, lap_o);
    end
    n_tests++; if (display_o !== sw_time) begin n_fail++; $display("FAIL reset_display: got %0d expected %0d", display_o, sw_time); end
    reset_i = 1'b0;
    tick_q.delete();
    clr_q.delete();
    step(3);
    n_tests++; if (state_o !== 2'b00 || tick_q.size() != 0) begin
      n_fail++; $display("FAIL idle_quiet: state=%b ticks=%0d expected 00 and 0", state_o, tick_q.size());
    end
  endtask

  task automatic test_start_tick();
    int   n0;
    int   obs;
    exp_t e;
    tick_q.delete();
    start_stop_i = 1'b1;
    step(1);
    n0 = cyc;
    n_tests++; if (state_o !== 2'b01) begin n_fail++; $display("FAIL start_state: got %b expected 01", state_o); end
    start_stop_i = 1'b0;
    for (int k = 0; k < 5; k++) exp_q.push_back('{"start_tick", n0 + TICK_DIV - 1 + TICK_DIV * k});
    step(20);
    n_tests++; if (sw_time !== 8'd5) begin n_fail++; $display("FAIL start_time: got %0d expected 5", sw_time); end
    n_tests++; if (display_o !== sw_time) begin n_fail++; $display("FAIL run_display: got %0d expected %0d", display_o, sw_time); end
    while (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      obs = (tick_q.size() != 0) ? tick_q.pop_front() : -1;
      n_tests++; if (obs !== e.val) begin n_fail++; $display("FAIL %s: tick at edge %0d expected %0d", e.name, obs, e.val); end
    end
    n_tests++; if (tick_q.size() != 0) begin n_fail++; $display("FAIL start_extra_ticks: got %0d expected 0", tick_q.size()); end
  endtask

  // Entered right after a wrap edge (presc=0); stopping two edges later leaves presc=2.
  task automatic test_stop_resume();
    int   r;
    int   obs;
    exp_t e;
    step(1);
    start_stop_i = 1'b1;
    step(1);
    n_tests++; if (state_o !== 2'b11) begin n_fail++; $display("FAIL stop_state: got %b expected 11", state_o); end
    start_stop_i = 1'b0;
    tick_q.delete();
    step(10);
    n_tests++; if (tick_q.size() != 0) begin n_fail++; $display("FAIL stopped_ticks: got %0d expected 0", tick_q.size()); end
    n_tests++; if (sw_time !== 8'd5) begin n_fail++; $display("FAIL stopped_time: got %0d expected 5", sw_time); end
    start_stop_i = 1'b1;
    step(1);
    r = cyc;
    n_tests++; if (state_o !== 2'b01) begin n_fail++; $display("FAIL resume_state: got %b expected 01", state_o); end
    start_stop_i = 1'b0;
    exp_q.push_back('{"resume_tick", r + 1});
    step(2);
    while (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      obs = (tick_q.size() != 0) ? tick_q.pop_front() : -1;
      n_tests++; if (obs !== e.val) begin n_fail++; $display("FAIL %s: tick at edge %0d expected %0d", e.name, obs, e.val); end
    end
    n_tests++; if (tick_q.size() != 0 || sw_time !== 8'd6) begin
      n_fail++; $display("FAIL resume_time: extra=%0d time=%0d expected 0 and 6", tick_q.size(), sw_time);
    end
  endtask

  task automatic test_lap();
    int guard = 0;
    while (sw_time != 8'd7 && guard < 40) begin
      step(1);
      guard++;
    end
    n_tests++; if (sw_time !== 8'd7) begin n_fail++; $display("FAIL lap_wait: time %0d expected 7 within 40 cycles", sw_time); end
    lap_reset_i = 1'b1;
    step(1);
    n_tests++; if (state_o !== 2'b10 || lap_o !== 1'b1) begin
      n_fail++; $display("FAIL lap_enter: state=%b lap=%b expected 10 1", state_o, lap_o);
    end
    lap_reset_i = 1'b0;
    step(8);
    n_tests++; if (sw_time !== 8'd9) begin n_fail++; $display("FAIL lap_counting: time %0d expected 9", sw_time); end
    n_tests++; if (display_o !== 8'd7) begin n_fail++; $display("FAIL lap_frozen: display %0d expected 7", display_o); end
    lap_reset_i = 1'b1;
    step(1);
    n_tests++; if (state_o !== 2'b01 || lap_o !== 1'b0) begin
      n_fail++; $display("FAIL lap_exit: state=%b lap=%b expected 01 0", state_o, lap_o);
    end
    n_tests++; if (display_o !== sw_time) begin n_fail++; $display("FAIL lap_live: display %0d expected %0d", display_o, sw_time); end
    lap_reset_i = 1'b0;
    step(1);
  endtask

  task automatic test_clear();
    int   c;
    int   s;
    int   obs;
    exp_t e;
    start_stop_i = 1'b1;
    step(1);
    start_stop_i = 1'b0;
    step(1);
    clr_q.delete();
    lap_reset_i = 1'b1;
    step(1);
    c = cyc;
    exp_q.push_back('{"stop_clear", c});
    n_tests++; if (state_o !== 2'b00 || clear_o !== 1'b1) begin
      n_fail++; $display("FAIL stop_clear_state: state=%b clear=%b expected 00 1", state_o, clear_o);
    end
    step(4);
    lap_reset_i = 1'b0;
    step(1);
    n_tests++; if (sw_time !== 8'd0) begin n_fail++; $display("FAIL cleared_time: got %0d expected 0", sw_time); end
    lap_reset_i = 1'b1;
    step(1);
    c = cyc;
    exp_q.push_back('{"idle_clear", c});
    n_tests++; if (state_o !== 2'b00 || clear_o !== 1'b1) begin
      n_fail++; $display("FAIL idle_clear_state: state=%b clear=%b expected 00 1", state_o, clear_o);
    end
    lap_reset_i = 1'b0;
    step(2);
    while (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      obs = (clr_q.size() != 0) ? clr_q.pop_front() : -1;
      n_tests++; if (obs !== e.val) begin n_fail++; $display("FAIL %s: clear at edge %0d expected %0d", e.name, obs, e.val); end
    end
    n_tests++; if (clr_q.size() != 0) begin n_fail++; $display("FAIL extra_clears: got %0d expected 0", clr_q.size()); end
    // Back to back: restart from IDLE, prescaler must start from zero.
    tick_q.delete();
    start_stop_i = 1'b1;
    step(1);
    s = cyc;
    start_stop_i = 1'b0;
    exp_q.push_back('{"restart_tick", s + TICK_DIV - 1});
    step(TICK_DIV);
    while (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      obs = (tick_q.size() != 0) ? tick_q.pop_front() : -1;
      n_tests++; if (obs !== e.val) begin n_fail++; $display("FAIL %s: tick at edge %0d expected %0d", e.name, obs, e.val); end
    end
  endtask

  task automatic test_simultaneous();
    clr_q.delete();
    start_stop_i = 1'b1;
    lap_reset_i  = 1'b1;
    step(1);
    n_tests++; if (state_o !== 2'b11 || lap_o !== 1'b0 || clear_o !== 1'b0) begin
      n_fail++; $display("FAIL simul_buttons: state=%b lap=%b clear=%b expected 11 0 0", state_o, lap_o, clear_o);
    end
    start_stop_i = 1'b0;
    lap_reset_i  = 1'b0;
    step(2);
    n_tests++; if (clr_q.size() != 0 || display_o !== sw_time) begin
      n_fail++; $display("FAIL simul_no_clear: clears=%0d display=%0d expected 0 and %0d", clr_q.size(), display_o, sw_time);
    end
  endtask

  task automatic test_held_reset();
    start_stop_i = 1'b1;
    lap_reset_i  = 1'b1;
    reset_i      = 1'b1;
    step(2);
    reset_i = 1'b0;
    clr_q.delete();
    step(3);
    n_tests++; if (state_o !== 2'b00 || clr_q.size() != 0) begin
      n_fail++; $display("FAIL held_reset: state=%b clears=%0d expected 00 and 0", state_o, clr_q.size());
    end
    start_stop_i = 1'b0;
    lap_reset_i  = 1'b0;
    step(1);
    start_stop_i = 1'b1;
    step(1);
    n_tests++; if (state_o !== 2'b01) begin n_fail++; $display("FAIL held_repress: state %b expected 01", state_o); end
    start_stop_i = 1'b0;
    step(1);
  endtask

  task automatic test_async_reset();
    lap_reset_i = 1'b1;
    step(1);
    n_tests++; if (state_o !== 2'b10) begin n_fail++; $display("FAIL async_setup: state %b expected 10", state_o); end
    lap_reset_i = 1'b0;
    step(2);
    #2;
    reset_i = 1'b1;
    #1;
    n_tests++; if (state_o !== 2'b00 || lap_o !== 1'b0 || count_o !== 1'b0 || clear_o !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: state=%b lap=%b count=%b clear=%b expected 00 0 0 0",
                         state_o, lap_o, count_o, clear_o);
    end
    n_tests++; if (display_o !== sw_time) begin n_fail++; $display("FAIL async_display: got %0d expected %0d", display_o, sw_time); end
    reset_i = 1'b0;
    step(2);
  endtask

  initial begin
    test_reset();
    test_start_tick();
    test_stop_resume();
    test_lap();
    test_clear();
    test_simultaneous();
    test_held_reset();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Button-level controller that sequences the `stopwatch` counter. It turns two raw push-button levels (start/stop, lap/reset) into the stopwatch's `count_i` tick enable and `clear_i` pulse. It also provides a lap (split-time) freeze of the displayed value. It sits between the board inputs and the `stopwatch` instance: `count_o` drives `count_i`, `clear_o` drives `clear_i`, and `time_o` returns on `time_i`.

## Interface
- `TICK_DIV`, default 4: clock cycles per stopwatch increment; legal values are 1 to 255.
- `WIDTH`, default 8: width of the time value.
- `clk_i`  input  1  system clock; all state changes on the rising edge.
- `reset_i`  input  1  asynchronous, active-high reset.
- `start_stop_i`  input  1  start/stop button level, already synchronised and debounced.
- `lap_reset_i`  input  1  lap/reset button level, already synchronised and debounced.
- `time_i`  input  WIDTH  current value from the stopwatch's `time_o`.
- `count_o`  output  1  tick enable to the stopwatch's `count_i`.
- `clear_o`  output  1  one-cycle clear to the stopwatch's `clear_i`.
- `display_o`  output  WIDTH  value to show: live `time_i`, or the latched lap value.
- `lap_o`  output  1  high while the display is frozen (state LAP).
- `state_o`  output  2  current state: IDLE=00, RUN=01, LAP=10, STOP=11.

## Operation
- **Edge detection**
  - Each button has a previous-value register, `ss_q` and `lr_q`, which reset to 1.
  - Events: `ss_ev = start_stop_i & ~ss_q` and `lr_ev = lap_reset_i & ~lr_q`.
  - Because the registers reset to 1, a button held through reset release produces no event until it is released and pressed again.
- **Priority:** if `ss_ev` and `lr_ev` occur in the same cycle, `ss_ev` wins and `lr_ev` is discarded.
- **Prescaler `presc`**
  - Width is ceil(log2(TICK_DIV)), with a minimum of 1 bit.
  - In RUN and LAP it increments each cycle and wraps from TICK_DIV-1 to 0.
  - In IDLE it is forced to 0.
  - In STOP it holds its value, so a resumed run keeps the phase of the partial tick.
- **Outputs**
  - `count_o` = (state is RUN or LAP) and (`presc` == TICK_DIV-1). With TICK_DIV=1, `count_o` is constantly 1 in RUN and LAP.
  - `display_o` = `lap_q` in LAP, otherwise `time_i`. This is a combinational pass-through.
  - `lap_o` = (state is LAP).
- **IDLE** (`count_o`=0)
  - `ss_ev` goes to RUN.
  - `lr_ev` sets `clear_o` for the next cycle and stays in IDLE.
- **RUN**
  - `ss_ev` goes to STOP.
  - `lr_ev` captures `time_i` into `lap_q` and goes to LAP.
- **LAP** (counting continues, display frozen)
  - `lr_ev` goes to RUN; the display returns to live.
  - `ss_ev` goes to STOP; the display is live in STOP.
- **STOP** (`count_o`=0)
  - `ss_ev` goes to RUN, with the prescaler resuming from its held value.
  - `lr_ev` sets `clear_o` for the next cycle and goes to IDLE, where `presc` is cleared.
- **`clear_o` register:** it is set at the edge where a qualifying `lr_ev` is sampled, and unconditionally returns to 0 at the next edge. It is never high for more than one cycle, even if the button is held.
- **Mid-operation reset:** asserting `reset_i` in any state immediately forces the reset values below, without waiting for a clock.

## Timing
- **Reset values:**
  - state IDLE (`state_o`=00), `presc`=0, `lap_q`=0, `ss_q`=`lr_q`=1.
  - `clear_o`=0, `count_o`=0, `lap_o`=0, `display_o`=`time_i`.
- **Button to state:** a button level first sampled high at edge N (with the previous sample low) changes `state_o` right after edge N.
- **First tick:**
  - The IDLE→RUN transition happens at edge N.
  - `count_o` first rises after edge N+TICK_DIV-1, so the stopwatch increments at edge N+TICK_DIV.
  - After that, `count_o` is high one cycle in every TICK_DIV cycles.
- **Clear:** for `lr_ev` at edge N, `clear_o` is high between edges N and N+1, and the stopwatch clears at edge N+1.
- **Lap capture:** `lap_q` takes the `time_i` value present before edge N.
- **Held buttons:** a level held high generates exactly one event; there is no auto-repeat.

## Test plan
- **Start and tick spacing:** reset, then press start/stop with TICK_DIV=4 → `state_o` 00→01; `count_o` pulses are exactly 4 cycles apart; the first pulse occurs 3 cycles after the transition; `time_i` from the stopwatch reaches 5 after 20 cycles.
- **Stop, resume, phase kept:** stop when `presc`=2, wait 10 cycles, then restart → no `count_o` while stopped; the first `count_o` after resume comes after 1 cycle; `time_i` is unchanged across the stop.
- **Lap freeze:**
  - Press lap/reset in RUN when `time_i`=7 → `lap_o`=1 and `display_o` stays 7 while `time_i` keeps advancing.
  - A second lap/reset press → state RUN and `display_o` equals the live `time_i`.
- **Clear paths:**
  - lap/reset in STOP → exactly one `clear_o` cycle, `state_o`=00, stopwatch reads 0.
  - lap/reset in IDLE → one `clear_o` cycle, state stays 00.
  - Holding the button 5 cycles → still exactly one `clear_o` pulse.
- **Simultaneous and held-through-reset buttons:**
  - Both buttons rising in the same cycle in RUN → STOP only; no lap capture, no `clear_o`.
  - Buttons held high across reset release → no transition until the buttons are released and pressed again.
- **Asynchronous reset mid-run:** assert `reset_i` in LAP between clock edges → outputs immediately take their reset values (`state_o`=00, `lap_o`=0, `count_o`=0) without waiting for a clock edge.
